// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM states, fault codes,
// coin codes and the coin code -> value table.
package change_dispenser_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PICK  = 3'd1,
        S_REQ   = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE      = 2'd0,
        FC_NO_CHANGE = 2'd1,
        FC_TIMEOUT   = 2'd2,
        FC_ABORTED   = 2'd3
    } fault_code_t;

    localparam logic [1:0] COIN_1  = 2'd0;
    localparam logic [1:0] COIN_2  = 2'd1;
    localparam logic [1:0] COIN_5  = 2'd2;
    localparam logic [1:0] COIN_10 = 2'd3;
    localparam int         NUM_COINS = 4;

    function automatic logic [3:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  coin_value = 4'd1;
            COIN_2:  coin_value = 4'd2;
            COIN_5:  coin_value = 4'd5;
            default: coin_value = 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Vend-controller / hopper signal bundle for the change dispenser.
// slave = dispenser side, master = controller/hopper side.
interface change_dispenser_if #(
    parameter int AMT_W = 8
);
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             abort;
    logic             fault_clr;
    logic [3:0]       hopper_empty;
    logic             dispense_ack;
    logic             dispense_req;
    logic [1:0]       dispense_coin;
    logic             busy;
    logic             done;
    logic             fault;
    logic [1:0]       fault_code;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] coins_out;

    modport slave (
        input  start, amount, abort, fault_clr, hopper_empty, dispense_ack,
        output dispense_req, dispense_coin, busy, done, fault, fault_code,
               remaining, coins_out
    );

    modport master (
        output start, amount, abort, fault_clr, hopper_empty, dispense_ack,
        input  dispense_req, dispense_coin, busy, done, fault, fault_code,
               remaining, coins_out
    );
endinterface

// File: rtl/change_dispenser_coin_picker.sv
// Combinational choice of the largest stocked coin that does not exceed
// the amount still owed.
module change_coin_picker
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic [AMT_W-1:0] i_remaining,
    input  logic [3:0]       i_hopper_empty,
    output logic             o_found,
    output logic [1:0]       o_code
);
    // Ascending scan: the last hit is the largest eligible denomination.
    always_comb begin
        o_found = 1'b0;
        o_code  = COIN_1;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (!i_hopper_empty[i] &&
                (AMT_W'(coin_value(2'(i))) <= i_remaining)) begin
                o_found = 1'b1;
                o_code  = 2'(i);
            end
        end
    end
endmodule

// File: rtl/change_dispenser.sv
// Change payout sequencer: one coin request per hopper handshake, largest
// stocked denomination first, with ack timeout, inter-coin gap and abort.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W       = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int GAP_CYCLES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    change_dispenser_if.slave  bus
);
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t           r_state, w_state_nxt;
    fault_code_t      r_fault_code, w_fcode_nxt;
    logic [AMT_W-1:0] r_remaining, w_remaining_nxt;
    logic [AMT_W-1:0] r_coins_out, w_coins_nxt;
    logic [1:0]       r_coin, w_coin_nxt;
    logic [TW-1:0]    r_timer, w_timer_nxt;
    logic [GW-1:0]    r_gap, w_gap_nxt;
    logic             w_found;
    logic [1:0]       w_code;

    function automatic logic [AMT_W-1:0] sat_inc(input logic [AMT_W-1:0] v);
        sat_inc = (v == '1) ? v : v + 1'b1;
    endfunction

    change_coin_picker #(.AMT_W(AMT_W)) u_picker (
        .i_remaining    (r_remaining),
        .i_hopper_empty (bus.hopper_empty),
        .o_found        (w_found),
        .o_code         (w_code)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_fcode_nxt     = r_fault_code;
        w_remaining_nxt = r_remaining;
        w_coins_nxt     = r_coins_out;
        w_coin_nxt      = r_coin;
        w_timer_nxt     = r_timer;
        w_gap_nxt       = r_gap;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.amount != '0) begin
                        w_remaining_nxt = bus.amount;
                        w_coins_nxt     = '0;
                        w_fcode_nxt     = FC_NONE;
                        w_state_nxt     = S_PICK;
                    end else begin
                        w_remaining_nxt = '0;
                        w_state_nxt     = S_DONE;
                    end
                end
            end
            S_PICK: begin
                if (bus.abort) begin
                    w_fcode_nxt = FC_ABORTED;
                    w_state_nxt = S_FAULT;
                end else if (r_remaining == '0) begin
                    w_state_nxt = S_DONE;
                end else if (w_found) begin
                    w_coin_nxt  = w_code;
                    w_timer_nxt = '0;
                    w_state_nxt = S_REQ;
                end else begin
                    w_fcode_nxt = FC_NO_CHANGE;
                    w_state_nxt = S_FAULT;
                end
            end
            S_REQ: begin
                // An ack always counts the coin, even alongside abort or timeout.
                if (bus.dispense_ack) begin
                    w_remaining_nxt = r_remaining - AMT_W'(coin_value(r_coin));
                    w_coins_nxt     = sat_inc(r_coins_out);
                    w_gap_nxt       = '0;
                    if (bus.abort) begin
                        w_fcode_nxt = FC_ABORTED;
                        w_state_nxt = S_FAULT;
                    end else begin
                        w_state_nxt = S_GAP;
                    end
                end else if (bus.abort) begin
                    w_fcode_nxt = FC_ABORTED;
                    w_state_nxt = S_FAULT;
                end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
                    w_fcode_nxt = FC_TIMEOUT;
                    w_state_nxt = S_FAULT;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    w_fcode_nxt = FC_ABORTED;
                    w_state_nxt = S_FAULT;
                end else if (r_gap == GW'(GAP_CYCLES - 1)) begin
                    w_state_nxt = S_PICK;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_FAULT: if (bus.fault_clr) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_fault_code <= FC_NONE;
            r_remaining  <= '0;
            r_coins_out  <= '0;
            r_coin       <= '0;
            r_timer      <= '0;
            r_gap        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_fault_code <= w_fcode_nxt;
            r_remaining  <= w_remaining_nxt;
            r_coins_out  <= w_coins_nxt;
            r_coin       <= w_coin_nxt;
            r_timer      <= w_timer_nxt;
            r_gap        <= w_gap_nxt;
        end
    end

    assign bus.dispense_req  = (r_state == S_REQ);
    assign bus.dispense_coin = r_coin;
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = (r_state == S_DONE);
    assign bus.fault         = (r_state == S_FAULT);
    assign bus.fault_code    = (r_state == S_FAULT) ? r_fault_code : FC_NONE;
    assign bus.remaining     = r_remaining;
    assign bus.coins_out     = r_coins_out;
endmodule
